// File: rtl/ice40_serdes_pll_ctrl_if.sv
// Control/status bundle between the SERDES PLL bring-up controller and its
// surroundings. Optional lock_loss_cnt exists only with SERDES_PLL_CTRL_STATS_EN.
interface ice40_serdes_pll_ctrl_if;
  logic       restart_req;
  logic       pll_lock;
  logic       pll_resetb;
  logic       crg_lock;
  logic       ready;
  logic       error;
  logic [2:0] state;
  logic [7:0] retry_cnt;
`ifdef SERDES_PLL_CTRL_STATS_EN
  logic [7:0] lock_loss_cnt;
`endif

`ifdef SERDES_PLL_CTRL_STATS_EN
  modport master (output restart_req, pll_lock,
                  input  pll_resetb, crg_lock, ready, error, state, retry_cnt, lock_loss_cnt);
  modport slave  (input  restart_req, pll_lock,
                  output pll_resetb, crg_lock, ready, error, state, retry_cnt, lock_loss_cnt);
`else
  modport master (output restart_req, pll_lock,
                  input  pll_resetb, crg_lock, ready, error, state, retry_cnt);
  modport slave  (input  restart_req, pll_lock,
                  output pll_resetb, crg_lock, ready, error, state, retry_cnt);
`endif
endinterface

// File: rtl/ice40_serdes_pll_ctrl.sv
// SERDES PLL bring-up and supervision controller.
// Runs on the free-running reference clock; sequences PLL reset, waits for
// lock with a timeout, qualifies lock before raising crg_lock, retries and
// latches a hard failure. Define SERDES_PLL_CTRL_STATS_EN to add the
// saturating lock_loss_cnt counter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET     | pll_resetb held low for RST_CYCLES cycles
// WAIT_LOCK | PLL released, waiting for synchronized lock (with timeout)
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | lock qualified, crg_lock/ready high
// FAIL      | MAX_RETRY attempts failed, PLL held in reset until restart
module ice40_serdes_pll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int TIMER_W       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  ice40_serdes_pll_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]         RETRY_LIMIT  = 8'(MAX_RETRY);

  state_t             state_q, nxt;
  logic [TIMER_W-1:0] timer_q;
  logic [7:0]         retry_q;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic               retry_inc;
  logic               lock_loss;
  logic               pll_resetb_q, crg_lock_q, ready_q, error_q;

  assign lock_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], bus.pll_lock};
  end

  // Next-state decision; restart_req overrides every other condition
  always_comb begin
    nxt       = state_q;
    retry_inc = 1'b0;
    lock_loss = 1'b0;
    if (bus.restart_req) begin
      nxt = S_RESET;
    end else begin
      case (state_q)
        S_RESET:     if (timer_q == RST_LAST) nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          // lock takes precedence over a coincident timeout
          if (lock_s) nxt = S_STABLE;
          else if (timer_q == TIMEOUT_LAST) begin
            retry_inc = 1'b1;
            nxt = (retry_q + 8'd1 == RETRY_LIMIT) ? S_FAIL : S_RESET;
          end
        end
        S_STABLE: begin
          if (!lock_s) nxt = S_WAIT_LOCK;
          else if (timer_q == STABLE_LAST) nxt = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            nxt       = S_RESET;
            lock_loss = 1'b1;
          end
        end
        S_FAIL:  nxt = S_FAIL;
        default: nxt = S_RESET;
      endcase
    end
  end

  // State, timer, retry counter and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      timer_q      <= '0;
      retry_q      <= 8'd0;
      pll_resetb_q <= 1'b0;
      crg_lock_q   <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q <= nxt;
      if (bus.restart_req || nxt != state_q) timer_q <= '0;
      else                                   timer_q <= timer_q + TIMER_W'(1);
      if (bus.restart_req || nxt == S_RUN) retry_q <= 8'd0;
      else if (retry_inc)                  retry_q <= retry_q + 8'd1;
      pll_resetb_q <= !(nxt == S_RESET || nxt == S_FAIL);
      crg_lock_q   <= (nxt == S_RUN);
      ready_q      <= (nxt == S_RUN);
      error_q      <= (nxt == S_FAIL);
    end
  end

`ifdef SERDES_PLL_CTRL_STATS_EN
  logic [7:0] loss_q;

  // Saturating count of lock losses while running; survives restart_req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          loss_q <= 8'd0;
    else if (lock_loss && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign bus.lock_loss_cnt = loss_q;
`endif

  assign bus.state      = state_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.pll_resetb = pll_resetb_q;
  assign bus.crg_lock   = crg_lock_q;
  assign bus.ready      = ready_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_ice40_serdes_pll_ctrl.sv
// Bench for ice40_serdes_pll_ctrl: directed scenarios with literal expectations
// followed by randomized lock/restart/reset stimulus against a behavioural model.
module tb_ice40_serdes_pll_ctrl;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int TIMER_W       = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ice40_serdes_pll_ctrl_if bus();

  ice40_serdes_pll_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // behavioural model: phase 0..4, cycles spent in phase, failures, losses
  int m_state, m_t, m_retry, m_loss;
  bit m_s0, m_s1;

  function automatic void m_reset();
    m_state = 0; m_t = 0; m_retry = 0; m_loss = 0; m_s0 = 1'b0; m_s1 = 1'b0;
  endfunction

  function automatic void m_go(int s);
    m_state = s; m_t = 0;
  endfunction

  function automatic void m_step(bit req, bit lock);
    bit ls;
    ls = m_s1;
    m_s1 = m_s0;
    m_s0 = lock;
    if (req) begin
      m_go(0); m_retry = 0;
      return;
    end
    case (m_state)
      0: if (m_t == RST_CYCLES - 1) m_go(1); else m_t++;
      1: begin
        if (ls) m_go(2);
        else if (m_t == LOCK_TIMEOUT - 1) begin
          m_retry++;
          m_go(m_retry == MAX_RETRY ? 4 : 0);
        end else m_t++;
      end
      2: begin
        if (!ls) m_go(1);
        else if (m_t == STABLE_CYCLES - 1) begin m_go(3); m_retry = 0; end
        else m_t++;
      end
      3: if (!ls) begin m_go(0); if (m_loss < 255) m_loss++; end
      default: ;
    endcase
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step(bus.restart_req, bus.pll_lock);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    bus.restart_req = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      32'(bus.state),     32'(m_state));
      chk("pll_resetb", 32'(bus.pll_resetb), 32'(!(m_state == 0 || m_state == 4)));
      chk("crg_lock",   32'(bus.crg_lock),  32'(m_state == 3));
      chk("ready",      32'(bus.ready),     32'(m_state == 3));
      chk("error",      32'(bus.error),     32'(m_state == 4));
      chk("retry_cnt",  32'(bus.retry_cnt), 32'(m_retry));
`ifdef SERDES_PLL_CTRL_STATS_EN
      chk("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(m_loss));
`endif
    end
  end

  initial begin
    bus.restart_req = 1'b0;
    bus.pll_lock    = 1'b1;
    m_reset();
    chk_en = 1'b1;

    // lock held high: release, qualify, run, lose lock, re-lock
    apply_reset();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pll_resetb", 32'(bus.pll_resetb), 0);
    chk("rst_retry", 32'(bus.retry_cnt), 0);
    ticks(3);
    chk("resetb_low_e3", 32'(bus.pll_resetb), 0);
    tick();
    chk("resetb_high_e4", 32'(bus.pll_resetb), 1);
    chk("wait_e4", 32'(bus.state), 1);
    tick();
    chk("stable_e5", 32'(bus.state), 2);
    ticks(7);
    chk("crg_low_e12", 32'(bus.crg_lock), 0);
    tick();
    chk("crg_high_e13", 32'(bus.crg_lock), 1);
    chk("ready_e13", 32'(bus.ready), 1);
    ticks(2);
    bus.pll_lock = 1'b0;
    ticks(2);
    chk("crg_hold_e17", 32'(bus.crg_lock), 1);
    tick();
    chk("crg_drop_e18", 32'(bus.crg_lock), 0);
    chk("reset_e18", 32'(bus.state), 0);
    chk("retry_e18", 32'(bus.retry_cnt), 0);
`ifdef SERDES_PLL_CTRL_STATS_EN
    chk("loss_e18", 32'(bus.lock_loss_cnt), 1);
`endif
    bus.pll_lock = 1'b1;
    ticks(12);
    chk("relock_low_e30", 32'(bus.crg_lock), 0);
    tick();
    chk("relock_high_e31", 32'(bus.crg_lock), 1);

    // one-cycle lock glitch at stable count 5
    apply_reset();
    ticks(10);
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    tick();
    chk("glitch_stable_e12", 32'(bus.state), 2);
    tick();
    chk("glitch_wait_e13", 32'(bus.state), 1);
    ticks(8);
    chk("glitch_crg_e21", 32'(bus.crg_lock), 0);
    tick();
    chk("glitch_run_e22", 32'(bus.state), 3);
    chk("glitch_retry_e22", 32'(bus.retry_cnt), 0);

    // no lock: two timeouts to FAIL, then restart
    bus.pll_lock = 1'b0;
    apply_reset();
    ticks(35);
    chk("to1_wait_e35", 32'(bus.state), 1);
    tick();
    chk("to1_reset_e36", 32'(bus.state), 0);
    chk("to1_retry_e36", 32'(bus.retry_cnt), 1);
    ticks(35);
    chk("to2_wait_e71", 32'(bus.state), 1);
    tick();
    chk("fail_e72", 32'(bus.state), 4);
    chk("fail_error", 32'(bus.error), 1);
    chk("fail_resetb", 32'(bus.pll_resetb), 0);
    tick();
    chk("fail_hold", 32'(bus.state), 4);
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    chk("restart_state", 32'(bus.state), 0);
    chk("restart_error", 32'(bus.error), 0);
    chk("restart_retry", 32'(bus.retry_cnt), 0);

    // restart coinciding with the first timeout
    apply_reset();
    ticks(35);
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    chk("to_restart_state", 32'(bus.state), 0);
    chk("to_restart_retry", 32'(bus.retry_cnt), 0);
    ticks(35);
    chk("to_restart_wait", 32'(bus.state), 1);
    tick();
    chk("to_restart_retry1", 32'(bus.retry_cnt), 1);
    chk("to_restart_reset", 32'(bus.state), 0);

    // asynchronous reset while in STABLE
    bus.pll_lock = 1'b1;
    apply_reset();
    ticks(8);
    chk("pre_areset_stable", 32'(bus.state), 2);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("areset_state", 32'(bus.state), 0);
    chk("areset_resetb", 32'(bus.pll_resetb), 0);
    chk("areset_crg", 32'(bus.crg_lock), 0);
    chk("areset_ready", 32'(bus.ready), 0);
    chk("areset_error", 32'(bus.error), 0);
    chk("areset_retry", 32'(bus.retry_cnt), 0);
`ifdef SERDES_PLL_CTRL_STATS_EN
    chk("areset_loss", 32'(bus.lock_loss_cnt), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized segments of lock behaviour with sporadic restarts and resets
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      int mode;
      len  = $urandom_range(5, 120);
      mode = $urandom_range(0, 5);
      for (int c = 0; c < len; c++) begin
        case (mode)
          0, 1, 2: bus.pll_lock = ($urandom_range(0, 99) != 0);
          3:       bus.pll_lock = 1'b0;
          4:       bus.pll_lock = $urandom_range(0, 1) != 0;
          default: bus.pll_lock = ($urandom_range(0, 9) != 0);
        endcase
        bus.restart_req = ($urandom_range(0, 199) == 0);
        tick();
      end
      bus.restart_req = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
